// File: rtl/itch_pkg.sv
// Shared types and constants for the ITCH transmit path.
// Holds the serializer state encoding and the header geometry.
package itch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        PAYLOAD
    } itch_tx_state_t;

    localparam int unsigned ITCH_HDR_BYTES = 3;
    localparam int unsigned ITCH_LEN_W     = 16;

endpackage

// File: rtl/itch_msg_serializer.sv
// Serialises one ITCH message per header handshake: type, length (big-endian), payload.
// Single registered output stage with backpressure; back-to-back messages need no bubble.
module itch_msg_serializer
    import itch_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD = 1500,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hdr_valid,
    output logic                  hdr_ready,
    input  logic [7:0]            hdr_type,
    input  logic [ITCH_LEN_W-1:0] hdr_len,
    input  logic [7:0]            pl_data,
    input  logic                  pl_valid,
    output logic                  pl_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_last,
    output logic                  busy,
    output logic                  msg_done,
    output logic                  err_oversize,
    output logic [CNT_W-1:0]      msg_count
);

    itch_tx_state_t        state_q, state_d;
    logic [ITCH_LEN_W-1:0] len_q, len_d;
    logic [ITCH_LEN_W-1:0] remaining_q, remaining_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  tx_last_q, tx_last_d;
    logic                  msg_done_q, msg_done_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      msg_count_q, msg_count_d;

    logic out_free;
    logic last_hs;

    // The output register can take a new byte when empty or when its byte leaves this cycle.
    assign out_free = !tx_valid_q || tx_ready;
    assign last_hs  = tx_valid_q && tx_ready && tx_last_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        tx_last_d   = tx_last_q;
        err_d       = 1'b0;
        hdr_ready   = 1'b0;
        pl_ready    = 1'b0;
        msg_done_d  = last_hs;
        msg_count_d = last_hs ? msg_count_q + CNT_W'(1) : msg_count_q;

        if (out_free) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                hdr_ready = out_free;
                if (hdr_valid && out_free) begin
                    if (32'(hdr_len) > MAX_PAYLOAD) begin
                        err_d = 1'b1;
                    end else begin
                        len_d      = hdr_len;
                        tx_data_d  = hdr_type;
                        tx_valid_d = 1'b1;
                        tx_last_d  = 1'b0;
                        state_d    = LEN_HI;
                    end
                end
            end
            LEN_HI: begin
                if (out_free) begin
                    tx_data_d  = len_q[15:8];
                    tx_valid_d = 1'b1;
                    tx_last_d  = 1'b0;
                    state_d    = LEN_LO;
                end
            end
            LEN_LO: begin
                if (out_free) begin
                    tx_data_d   = len_q[7:0];
                    tx_valid_d  = 1'b1;
                    tx_last_d   = (len_q == '0);
                    remaining_d = len_q;
                    state_d     = (len_q == '0) ? IDLE : PAYLOAD;
                end
            end
            PAYLOAD: begin
                pl_ready = out_free;
                if (pl_valid && out_free) begin
                    tx_data_d  = pl_data;
                    tx_valid_d = 1'b1;
                    tx_last_d  = (remaining_q == ITCH_LEN_W'(1));
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - ITCH_LEN_W'(1);
                    end
                    if (remaining_q <= ITCH_LEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            remaining_q <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            msg_done_q  <= 1'b0;
            err_q       <= 1'b0;
            msg_count_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_last_q   <= tx_last_d;
            msg_done_q  <= msg_done_d;
            err_q       <= err_d;
            msg_count_q <= msg_count_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign tx_last      = tx_last_q;
    assign msg_done     = msg_done_q;
    assign err_oversize = err_q;
    assign msg_count    = msg_count_q;
    assign busy         = (state_q != IDLE) || tx_valid_q;

endmodule

// File: tb/tb_itch_msg_serializer.sv
// Bench for itch_msg_serializer: queue-based message model plus directed scenarios.
// Expected byte streams are built from header/payload descriptions, not from DUT state.
module tb_itch_msg_serializer;

    localparam int unsigned MAX = 1500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hdr_valid, hdr_ready;
    logic [7:0]  hdr_type;
    logic [15:0] hdr_len;
    logic [7:0]  pl_data;
    logic        pl_valid, pl_ready;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, tx_last;
    logic        busy, msg_done, err_oversize;
    logic [31:0] msg_count;

    always #5 clk = ~clk;

    itch_msg_serializer #(.MAX_PAYLOAD(MAX), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .hdr_valid    (hdr_valid),
        .hdr_ready    (hdr_ready),
        .hdr_type     (hdr_type),
        .hdr_len      (hdr_len),
        .pl_data      (pl_data),
        .pl_valid     (pl_valid),
        .pl_ready     (pl_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_last      (tx_last),
        .busy         (busy),
        .msg_done     (msg_done),
        .err_oversize (err_oversize),
        .msg_count    (msg_count)
    );

    typedef struct {logic [7:0] d; logic last;} exp_t;
    typedef struct {logic [7:0] t; logic [15:0] l;} hdr_t;
    typedef logic [7:0] bq_t[$];

    exp_t        exp_q[$];
    hdr_t        hq[$];
    logic [7:0]  pq[$];
    logic [7:0]  hs_d[$];
    logic        hs_l[$];
    time         hs_t[$];
    time         last_t[$];
    time         acc_t[$];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int model_count = 0;
    int valid_cnt, plr_cnt, err_cnt, stall_cnt;
    int rdy_mode = 0;
    bit pl_gap_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic bq_t mk_pl(input int n, input logic [7:0] b);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(b + 8'(i * 17));
        return q;
    endfunction

    // Message model: header then big-endian length then payload; last flag on final byte.
    task automatic push_msg(input logic [7:0] t, input logic [15:0] l, input bq_t pl);
        hdr_t h;
        h.t = t;
        h.l = l;
        hq.push_back(h);
        if (32'(l) <= MAX) begin
            exp_q.push_back('{d: t, last: 1'b0});
            exp_q.push_back('{d: l[15:8], last: 1'b0});
            exp_q.push_back('{d: l[7:0], last: (l == 16'd0)});
            for (int i = 0; i < int'(l); i++) begin
                exp_q.push_back('{d: pl[i], last: (i == int'(l) - 1)});
                pq.push_back(pl[i]);
            end
        end
    endtask

    task automatic clear_logs();
        hs_d.delete(); hs_l.delete(); hs_t.delete(); last_t.delete(); acc_t.delete();
        valid_cnt = 0; plr_cnt = 0; err_cnt = 0; stall_cnt = 0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0 && hq.size() == 0 && !busy) break;
        end
        chk("drain_in_budget", 32'(k < budget), 32'd1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic chk_seq(input string name, input bq_t req);
        chk({name, "_len"}, 32'(hs_d.size()), 32'(req.size()));
        for (int i = 0; i < req.size() && i < hs_d.size(); i++)
            chk({name, "_byte"}, 32'(hs_d[i]), 32'(req[i]));
    endtask

    // Header driver
    initial begin
        bit acc;
        hdr_valid = 0; hdr_type = 0; hdr_len = 0;
        forever begin
            if (rst) hq.delete();
            if (hq.size() > 0) begin
                hdr_valid = 1; hdr_type = hq[0].t; hdr_len = hq[0].l;
            end else begin
                hdr_valid = 0;
            end
            @(negedge clk);
            acc = hdr_valid && hdr_ready && !rst;
            if (acc) acc_t.push_back($time);
            @(posedge clk); #1;
            if (acc && hq.size() > 0) void'(hq.pop_front());
        end
    end

    // Payload driver, with optional periodic gaps
    initial begin
        bit acc;
        pl_valid = 0; pl_data = 0;
        forever begin
            if (rst) pq.delete();
            if (pq.size() > 0 && !(pl_gap_en && (cyc % 3 == 0))) begin
                pl_valid = 1; pl_data = pq[0];
            end else begin
                pl_valid = 0;
            end
            @(negedge clk);
            acc = pl_valid && pl_ready && !rst;
            @(posedge clk); #1;
            if (acc && pq.size() > 0) void'(pq.pop_front());
        end
    end

    // Sink: always ready, or a 1,0,0 ready pattern
    initial begin
        int step = 0;
        tx_ready = 1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0) begin
                tx_ready = 1;
            end else begin
                tx_ready = (step % 3 == 0);
                step++;
            end
        end
    end

    // Compare process
    initial begin
        bit prev_last = 0, exp_err = 0, holding = 0, held_l = 0;
        logic [7:0] held_d = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete();
                prev_last = 0; exp_err = 0; holding = 0; model_count = 0;
            end else begin
                chk("msg_done", 32'(msg_done), 32'(prev_last));
                chk("err_oversize", 32'(err_oversize), 32'(exp_err));
                chk("msg_count", msg_count, 32'(model_count));
                if (holding) begin
                    chk("stall_valid", 32'(tx_valid), 32'd1);
                    chk("stall_data", 32'(tx_data), 32'(held_d));
                    chk("stall_last", 32'(tx_last), 32'(held_l));
                end
                prev_last = 0;
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_byte: got 0x%0h required no byte", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_data", 32'(tx_data), 32'(e.d));
                        chk("tx_last", 32'(tx_last), 32'(e.last));
                        if (e.last) begin
                            model_count++;
                            prev_last = 1;
                        end
                    end
                    hs_d.push_back(tx_data); hs_l.push_back(tx_last); hs_t.push_back($time);
                    if (tx_last) last_t.push_back($time);
                end
                holding = tx_valid && !tx_ready;
                held_d = tx_data; held_l = tx_last;
                if (holding) stall_cnt++;
                exp_err = hdr_valid && hdr_ready && (32'(hdr_len) > MAX);
                if (tx_valid) valid_cnt++;
                if (pl_ready) plr_cnt++;
                if (err_oversize) err_cnt++;
            end
        end
    end

    initial begin
        int k;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_msg_count", msg_count, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 0;

        // 1: basic message
        clear_logs();
        push_msg(8'h41, 16'h0003, mk_pl(3, 8'hAA));
        wait_done(200);
        chk_seq("t1", '{8'h41, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC});
        if (hs_t.size() == 6) chk("t1_consecutive", 32'((hs_t[5] - hs_t[0]) / 10), 32'd5);
        if (acc_t.size() > 0 && hs_t.size() > 0)
            chk("t1_latency", 32'((hs_t[0] - acc_t[0]) / 10), 32'd1);
        chk("t1_last_count", 32'(last_t.size()), 32'd1);
        chk("t1_msg_count", msg_count, 32'd1);

        // 2: zero-length message
        clear_logs();
        push_msg(8'h53, 16'h0000, mk_pl(0, 8'h00));
        wait_done(200);
        chk_seq("t2", '{8'h53, 8'h00, 8'h00});
        if (hs_l.size() == 3) chk("t2_last_on_third", 32'({hs_l[0], hs_l[1], hs_l[2]}), 32'b001);
        chk("t2_pl_ready_never", 32'(plr_cnt), 32'd0);
        chk("t2_msg_count", msg_count, 32'd2);

        // 3: two back-to-back messages, len 1 each -> 8 bytes in 8 cycles
        clear_logs();
        push_msg(8'h61, 16'h0001, mk_pl(1, 8'h10));
        push_msg(8'h62, 16'h0001, mk_pl(1, 8'h20));
        wait_done(200);
        chk_seq("t3", '{8'h61, 8'h00, 8'h01, 8'h10, 8'h62, 8'h00, 8'h01, 8'h20});
        if (hs_t.size() == 8) chk("t3_consecutive", 32'((hs_t[7] - hs_t[0]) / 10), 32'd7);
        if (acc_t.size() == 2 && last_t.size() == 2)
            chk("t3_hdr_on_last", 32'(acc_t[1] == last_t[0]), 32'd1);
        chk("t3_msg_count", msg_count, 32'd4);

        // 4: backpressure
        clear_logs();
        rdy_mode = 1;
        push_msg(8'h42, 16'h0003, mk_pl(3, 8'h01));
        wait_done(400);
        rdy_mode = 0;
        chk_seq("t4", '{8'h42, 8'h00, 8'h03, 8'h01, 8'h12, 8'h23});
        chk("t4_stalled", 32'(stall_cnt > 0), 32'd1);
        chk("t4_msg_count", msg_count, 32'd5);

        // 5: oversize header dropped, then a legal one
        clear_logs();
        push_msg(8'h55, 16'(MAX + 1), mk_pl(0, 8'h00));
        wait_done(100);
        chk("t5_err_pulses", 32'(err_cnt), 32'd1);
        chk("t5_no_valid", 32'(valid_cnt), 32'd0);
        chk("t5_msg_count", msg_count, 32'd5);
        clear_logs();
        push_msg(8'h56, 16'h0002, mk_pl(2, 8'h70));
        wait_done(200);
        chk_seq("t5b", '{8'h56, 8'h00, 8'h02, 8'h70, 8'h81});
        chk("t5b_msg_count", msg_count, 32'd6);

        // 7: payload gaps
        clear_logs();
        pl_gap_en = 1;
        push_msg(8'h47, 16'h0004, mk_pl(4, 8'h30));
        wait_done(400);
        pl_gap_en = 0;
        chk_seq("t7", '{8'h47, 8'h00, 8'h04, 8'h30, 8'h41, 8'h52, 8'h63});
        chk("t7_msg_count", msg_count, 32'd7);

        // 6: reset after the LEN_HI byte
        clear_logs();
        push_msg(8'h50, 16'h0002, mk_pl(2, 8'h90));
        for (k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (hs_d.size() >= 2) break;
        end
        chk("t6_reached_len_hi", 32'(k < 100), 32'd1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_no_last", 32'(last_t.size()), 32'd0);
        chk("t6_tx_valid", 32'(tx_valid), 32'd0);
        chk("t6_tx_data", 32'(tx_data), 32'd0);
        chk("t6_tx_last", 32'(tx_last), 32'd0);
        chk("t6_msg_done", 32'(msg_done), 32'd0);
        chk("t6_err", 32'(err_oversize), 32'd0);
        chk("t6_msg_count", msg_count, 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_pl_ready", 32'(pl_ready), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        clear_logs();
        push_msg(8'h51, 16'h0001, mk_pl(1, 8'hEE));
        wait_done(200);
        chk_seq("t6b", '{8'h51, 8'h00, 8'h01, 8'hEE});
        chk("t6b_msg_count", msg_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
